// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a lookup function only).
// Backpressure: n/a.
package keypad_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAND    = 2'd1,
        PRESSED = 2'd2,
        REL     = 2'd3
    } kp_state_e;

    // Outcome of one full 4-column scan frame.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } frame_res_e;

    // Hex code per key. The index is c*4+r, so element 0 is row 0 / column 0.
    // Layout by row: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,     // c3: r3..r0
        4'hE, 4'h9, 4'h6, 4'h3,     // c2
        4'hF, 4'h8, 4'h5, 4'h2,     // c1
        4'h0, 4'h7, 4'h4, 4'h1      // c0
    };

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        return KEY_MAP[idx];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signal bundle of the keypad scanner.
// Latency: n/a (wires only).
// Backpressure: none; KEYSTROBE is a fire-and-forget one-cycle event.
// Ports: ROW (keypad rows, active-low), COL (column drive, one-hot active-low),
//        KEYVAL (last accepted key), KEYDOWN (debounced held level), KEYSTROBE (press event).
// master = scanner side, slave = keypad + downstream consumer side.
interface keypad_scanner_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEYVAL;
    logic       KEYDOWN;
    logic       KEYSTROBE;

    modport master (
        input  ROW,
        output COL,
        output KEYVAL,
        output KEYDOWN,
        output KEYSTROBE
    );

    modport slave (
        output ROW,
        input  COL,
        input  KEYVAL,
        input  KEYDOWN,
        input  KEYSTROBE
    );
endinterface

// File: rtl/keypad_col_scan.sv
// Column scanner: drives one column per dwell, samples rows, classifies each 4-column frame.
// Latency: frame result valid (frame_done_o pulse) the cycle after the column-3 sample.
// Backpressure: none; the result is a one-cycle pulse that the consumer must take.
// Ports: clk_i, rst_ni (async active-low), row_i (synchronised rows, active-low),
//        col_o (column drive), frame_done_o, frame_res_o (NONE/KEY/MULTI), frame_code_o.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       frame_done_o,
    output frame_res_e frame_res_o,
    output logic [3:0] frame_code_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;   // hits so far this frame, saturating at 2
    logic [3:0]    acc_idx_q, acc_idx_d;   // c*4+r of the first (lowest-index) hit
    logic          done_q, done_d;
    frame_res_e    res_q, res_d;
    logic [3:0]    code_q, code_d;

    logic          last_dwell;
    logic [2:0]    col_hits;
    logic [1:0]    first_row;
    logic [2:0]    tot_hits;
    logic [1:0]    mrg_cnt;
    logic [3:0]    mrg_idx;

    always_comb begin
        last_dwell = (dwell_q == DW'(SCAN_DIV - 1));

        // Hits in the current column; scanning rows from the top down leaves
        // first_row at the lowest active row.
        col_hits  = 3'd0;
        first_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_i[r]) begin
                col_hits  = col_hits + 3'd1;
                first_row = 2'(r);
            end
        end

        // Columns are visited in ascending order, so the first hit ever seen
        // in the frame is the lowest c*4+r; later hits never replace it.
        tot_hits = {1'b0, acc_cnt_q} + col_hits;
        mrg_cnt  = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
        mrg_idx  = (acc_cnt_q == 2'd0) ? {col_q, first_row} : acc_idx_q;

        dwell_d   = last_dwell ? '0 : dwell_q + DW'(1);
        col_d     = last_dwell ? col_q + 2'd1 : col_q;
        acc_cnt_d = acc_cnt_q;
        acc_idx_d = acc_idx_q;
        done_d    = 1'b0;
        res_d     = res_q;
        code_d    = code_q;

        if (last_dwell) begin
            if (col_q == 2'd3) begin
                done_d    = 1'b1;
                code_d    = key_code(mrg_idx);
                acc_cnt_d = 2'd0;
                acc_idx_d = 4'd0;
                case (mrg_cnt)
                    2'd0:    res_d = NONE;
                    2'd1:    res_d = KEY;
                    default: res_d = MULTI;
                endcase
            end else begin
                acc_cnt_d = mrg_cnt;
                acc_idx_d = mrg_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dwell_q   <= '0;
            col_q     <= 2'd0;
            acc_cnt_q <= 2'd0;
            acc_idx_q <= 4'd0;
            done_q    <= 1'b0;
            res_q     <= NONE;
            code_q    <= 4'd0;
        end else begin
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            acc_cnt_q <= acc_cnt_d;
            acc_idx_q <= acc_idx_d;
            done_q    <= done_d;
            res_q     <= res_d;
            code_q    <= code_d;
        end
    end

    assign col_o        = ~(4'b0001 << col_q);
    assign frame_done_o = done_q;
    assign frame_res_o  = res_q;
    assign frame_code_o = code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row synchroniser, column scan, frame debounce, hex key output.
// Latency: press stable from a frame start -> KEYSTROBE DEBOUNCE_SCANS frames later + 1 cycle.
// Backpressure: none; KEYSTROBE is a one-cycle event, KEYVAL/KEYDOWN are held levels.
// Ports: CLK100MHZ, RSTN (async active-low), kp (keypad_scanner_if.master: ROW in;
//        COL, KEYVAL, KEYDOWN, KEYSTROBE out).
// Build option: define KEYPAD_GHOST_REJECT_EN to reject multi-key frames instead of
//        resolving them to the lowest-index key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic                      CLK100MHZ,
    input  logic                      RSTN,
    keypad_scanner_if.master          kp
);

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST_REJECT = 1'b1;
`else
    localparam bit GHOST_REJECT = 1'b0;
`endif

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    // Rows idle high (external pull-ups), so the synchroniser resets to all-ones.
    logic [3:0] row_s1_q, row_s2_q;

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= kp.ROW;
            row_s2_q <= row_s1_q;
        end
    end

    logic       frame_done;
    frame_res_e frame_res;
    logic [3:0] frame_code;
    logic [3:0] col;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk_i        (CLK100MHZ),
        .rst_ni       (RSTN),
        .row_i        (row_s2_q),
        .col_o        (col),
        .frame_done_o (frame_done),
        .frame_res_o  (frame_res),
        .frame_code_o (frame_code)
    );

    kp_state_e   state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  keyval_q, keyval_d;
    logic        keydown_q, keydown_d;
    logic        strobe_q, strobe_d;

    logic        key_seen;   // frame yields a usable key code
    logic        any_down;   // frame shows at least one key closed
    logic [CW:0] cnt_inc;
    logic        cnt_full;

    always_comb begin
        // With ghost rejection a multi-key frame never produces a code, but it
        // still counts as "something held" once a key has been accepted.
        key_seen = (frame_res == KEY) || (!GHOST_REJECT && (frame_res == MULTI));
        any_down = (frame_res != NONE);
        cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
        cnt_full = (cnt_inc >= (CW+1)'(DEBOUNCE_SCANS));

        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        keyval_d  = keyval_q;
        keydown_d = keydown_q;
        strobe_d  = 1'b0;

        if (frame_done) begin
            case (state_q)
                IDLE: begin
                    if (key_seen) begin
                        cand_d = frame_code;
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d   = PRESSED;
                            cnt_d     = '0;
                            keyval_d  = frame_code;
                            keydown_d = 1'b1;
                            strobe_d  = 1'b1;
                        end else begin
                            state_d = CAND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                CAND: begin
                    if (key_seen) begin
                        if (frame_code == cand_q) begin
                            if (cnt_full) begin
                                state_d   = PRESSED;
                                cnt_d     = '0;
                                keyval_d  = cand_q;
                                keydown_d = 1'b1;
                                strobe_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_inc[CW-1:0];
                            end
                        end else begin
                            cand_d = frame_code;
                            cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    // Key changes while held are ignored until a clean release.
                    if (!any_down) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            keydown_d = 1'b0;
                        end else begin
                            state_d = REL;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                REL: begin
                    if (!any_down) begin
                        if (cnt_full) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            keydown_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc[CW-1:0];
                        end
                    end else begin
                        // Release glitch: back to held without a fresh strobe.
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= '0;
            keyval_q  <= 4'd0;
            keydown_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            keyval_q  <= keyval_d;
            keydown_q <= keydown_d;
            strobe_q  <= strobe_d;
        end
    end

    assign kp.COL       = col;
    assign kp.KEYVAL    = keyval_q;
    assign kp.KEYDOWN   = keydown_q;
    assign kp.KEYSTROBE = strobe_q;

endmodule
